ps2_keyboard_rx: RTL and testbench

Receives serial frames from a PS/2 keyboard and decodes the scan-code stream (make, `E0` extended, `F0` break) into a held-key level. It sits directly upstream of the rising-edge pulse stage: `key_held` drives that stage's `Din`, and the resulting 1-clock pulse triggers game input handling. Raw `ps2_clk`/`ps2_data` are asynchronous open-collector lines. This block synchronizes and filters them, checks each frame, and reports errors.

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_clk_filter.sv | 49 ++++
 rtl/ps2_keyboard_rx.sv | 157 +++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame-FSM state type for the PS/2 keyboard receiver.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;
endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 lines and debounces the clock; emits a one-cycle
// sample strobe on each filtered falling edge together with the data bit.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sample,
    output logic data
);
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_f;
    logic [7:0] filt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // filt_cnt counts consecutive synchronized samples that disagree with clk_f.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_f    <= 1'b1;
            filt_cnt <= '0;
            sample   <= 1'b0;
            data     <= 1'b1;
        end else begin
            sample <= 1'b0;
            data   <= data_sync[1];
            if (clk_sync[1] == clk_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                clk_f    <= clk_sync[1];
                sample   <= clk_f & ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame FSM with timeout, then a scan-code decoder
// that turns make / E0 / F0 sequences into a held-key level.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_held
);
    localparam int         TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 2);

    logic          sample;
    logic          data_s;
    state_t        state, state_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          par_bit, par_nx;
    logic [TW-1:0] tmo_cnt, tmo_nx;
    logic [7:0]    rx_data_nx;
    logic          done_nx, err_nx;
    logic          ext_pend, brk_pend, switch_pend;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sample   (sample),
        .data     (data_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
            rx_data <= '0;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
            par_bit <= par_nx;
            tmo_cnt <= tmo_nx;
            rx_data <= rx_data_nx;
            rx_done <= done_nx;
            rx_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par_bit;
        tmo_nx     = '0;
        rx_data_nx = rx_data;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (sample) begin
                    if (!data_s) begin
                        state_nx   = RECV;
                        bit_cnt_nx = '0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            RECV: begin
                // A sample in the same cycle as the timeout takes priority.
                if (sample) begin
                    if (bit_cnt < 4'd8) begin
                        shreg_nx   = {data_s, shreg[7:1]};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (bit_cnt < STOP_IDX) begin
                        par_nx     = data_s;
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else begin
                        state_nx = IDLE;
                        if ((^shreg ^ par_bit) && data_s) begin
                            rx_data_nx = shreg;
                            done_nx    = 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end
                end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    tmo_nx = tmo_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Switching keys without a break drops key_held for one cycle so the
    // downstream edge detector sees a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            switch_pend <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            if (switch_pend) begin
                key_held    <= 1'b1;
                switch_pend <= 1'b0;
            end
            if (rx_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (rx_done) begin
                if (rx_data == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_data == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (brk_pend) begin
                        if (key_held && rx_data == key_code && ext_pend == key_ext)
                            key_held <= 1'b0;
                    end else if (!key_held) begin
                        key_code <= rx_data;
                        key_ext  <= ext_pend;
                        key_held <= 1'b1;
                    end else if (rx_data != key_code || ext_pend != key_ext) begin
                        key_code    <= rx_data;
                        key_ext     <= ext_pend;
                        key_held    <= 1'b0;
                        switch_pend <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames, scores rx events from a queue
// and checks the held-key level after each frame.
module tb_ps2_keyboard_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_held;

    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .key_code (key_code),
        .key_ext  (key_ext),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rises = 0;
    int low_run = 0;
    int last_low = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    logic prev_held = 1'b0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on rx strobes, key_held edge tracking.
    always @(negedge clk) begin
        logic [8:0] act;
        cyc++;
        if (!rst) begin
            if (rx_done || rx_err) begin
                check("strobe_excl", {31'd0, rx_done & rx_err}, 32'd0);
                check("strobe_len", {30'd0, prev_done, prev_err}, 32'd0);
                act = rx_err ? 9'h100 : {1'b0, rx_data};
                if (rx_done) done_cnt++;
                if (rx_err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (exp_q.size() == 0) check("unexp_evt", {23'd0, act}, 32'h1FF);
                else check("rx_evt", {23'd0, act}, {23'd0, exp_q.pop_front()});
            end
        end
        prev_done = rx_done;
        prev_err  = rx_err;
        if (key_held) begin
            if (!prev_held) begin
                rises++;
                last_low = low_run;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_held = key_held;
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (50) @(negedge clk);
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        repeat (100) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
        logic par;
        par = ~^b ^ par_bad;
        exp_q.push_back((par_bad || !stop) ? 9'h100 : {1'b0, b});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic check_key(input string tag, input logic held, input logic [7:0] code, input logic ext);
        check({tag, "_held"}, {31'd0, key_held}, {31'd0, held});
        check({tag, "_code"}, {24'd0, key_code}, {24'd0, code});
        check({tag, "_ext"}, {31'd0, key_ext}, {31'd0, ext});
    endtask

    initial begin
        int r0, d0, e0, delta;
        logic [7:0] tmp;
        repeat (3) @(negedge clk);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_strobes", {30'd0, rx_done, rx_err}, 32'd0);
        check_key("rst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Basic frame and make/repeat/break.
        d0 = done_cnt;
        send_good(8'h1C);
        wait_drain(100);
        check("basic_rx_data", {24'd0, rx_data}, 32'h1C);
        check_key("basic", 1'b1, 8'h1C, 1'b0);
        send_good(8'h1C);
        check_key("repeat", 1'b1, 8'h1C, 1'b0);
        send_good(8'hF0);
        check_key("brk_pend", 1'b1, 8'h1C, 1'b0);
        send_good(8'h1C);
        wait_drain(100);
        check_key("break", 1'b0, 8'h1C, 1'b0);
        check("mb_rises", rises, 32'd1);
        check("mb_done_cnt", done_cnt - d0, 32'd4);

        // Extended make, mismatched plain break, extended break.
        send_good(8'hE0);
        send_good(8'h75);
        check_key("ext_make", 1'b1, 8'h75, 1'b1);
        send_good(8'hF0);
        send_good(8'h75);
        check_key("plain_brk", 1'b1, 8'h75, 1'b1);
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        wait_drain(100);
        check_key("ext_brk", 1'b0, 8'h75, 1'b1);

        // Key switch without a break.
        r0 = rises;
        send_good(8'h1C);
        send_good(8'h32);
        wait_drain(100);
        check_key("switch", 1'b1, 8'h32, 1'b0);
        check("switch_rises", rises - r0, 32'd2);
        check("switch_low_len", last_low, 32'd1);
        send_good(8'hF0);
        send_good(8'h32);
        check_key("switch_rel", 1'b0, 8'h32, 1'b0);

        // Frame errors.
        d0 = done_cnt;
        e0 = err_cnt;
        tmp = rx_data;
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        exp_q.push_back(9'h100);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
        wait_drain(100);
        check("err_cnt", err_cnt - e0, 32'd3);
        check("err_no_done", done_cnt - d0, 32'd0);
        check("err_rx_data", {24'd0, rx_data}, {24'd0, tmp});
        check_key("err_keys", 1'b0, 8'h32, 1'b0);
        send_good(8'hE0);
        send_frame(8'h44, 1'b1, 1'b1);
        send_good(8'h75);
        check_key("err_clr_ext", 1'b1, 8'h75, 1'b0);
        send_good(8'hF0);
        send_good(8'h75);
        check_key("err_clr_rel", 1'b0, 8'h75, 1'b0);

        // Short clock glitch while idle: any sample would raise rx_err.
        e0 = err_cnt;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_evt", err_cnt - e0, 32'd0);

        // Timeout after five bits, then a clean frame.
        exp_q.push_back(9'h100);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_drain(3000);
        delta = err_cyc - fall_cyc;
        check("tmo_latency", {31'd0, (delta >= 1995 && delta <= 2015)}, 32'd1);
        send_good(8'h1C);
        wait_drain(100);
        check_key("after_tmo", 1'b1, 8'h1C, 1'b0);

        // Reset mid-frame.
        e0 = err_cnt;
        d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_strobes", {30'd0, rx_done, rx_err}, 32'd0);
        check_key("mid_rst", 1'b0, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_no_evt", (err_cnt - e0) + (done_cnt - d0), 32'd0);
        send_good(8'h1C);
        wait_drain(100);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h1C);
        check_key("post_rst", 1'b1, 8'h1C, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
